xgriscv_fetch_queue: RTL and testbench

XGRISCV_FETCH_QUEUE -- requirements
Module: xgriscv_fetch_queue

---
 rtl/xgriscv_fetch_queue.sv | 142 ++++++++++++++
 tb/tb_xgriscv_fetch_queue.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/xgriscv_fetch_queue.sv
// rtl/xgriscv_fetch_queue.sv - fetch-to-decode instruction queue with flush and optional bypass
//
// Purpose:
//   Small circular FIFO between the fetch and decode stages. Each entry holds an
//   instruction and its PC. A flush (branch/jump redirect) discards every held
//   entry. The head PC is also presented pre-incremented by 4.
//
// Optional feature:
//   XGRISCV_FQ_BYPASS_EN - when defined, an entry offered to an empty queue is
//   presented to decode in the same cycle. It is stored only if decode does not
//   take it in that cycle.
//
// Parameters:
//   ADDR_W  - PC width in bits
//   INSTR_W - instruction width in bits
//   DEPTH   - entry count (power of two, >= 2)
//
// Ports:
//   clk         - clock, all state updates on the rising edge
//   reset       - synchronous active-high reset
//   flush       - redirect, discards all entries at the next edge
//   in_valid    - fetch offers an entry
//   in_ready    - queue accepts the offered entry
//   in_instr    - offered instruction
//   in_pc       - offered PC
//   out_valid   - head entry presented to decode
//   out_ready   - decode consumes the head entry
//   out_instr   - head instruction (NOP when out_valid is 0)
//   out_pc      - head PC (0 when out_valid is 0)
//   out_pcplus4 - head PC + 4 (0 when out_valid is 0)
//   count       - number of held entries

module xgriscv_fetch_queue #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [INSTR_W-1:0]         in_instr,
    input  logic [ADDR_W-1:0]          in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INSTR_W-1:0]         out_instr,
    output logic [ADDR_W-1:0]          out_pc,
    output logic [ADDR_W-1:0]          out_pcplus4,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]   FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [31:0]        NOP_32    = 32'h0000_0013;
    localparam logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_32);

    // Entry storage is deliberately left out of reset/flush: only the pointers
    // and the count define which slots are meaningful.
    logic [INSTR_W-1:0] r_mem_instr [DEPTH];
    logic [ADDR_W-1:0]  r_mem_pc    [DEPTH];

    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_empty;
    logic               w_full;
    logic               w_head_valid;
    logic               w_bypass;
    logic               w_push;
    logic               w_pop;
    logic [ADDR_W-1:0]  w_head_pc;
    logic [INSTR_W-1:0] w_head_instr;

    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == FULL_CNT);
    assign w_head_valid = !w_empty && !flush;

`ifdef XGRISCV_FQ_BYPASS_EN
    // Empty queue forwards the offered entry straight to decode.
    assign w_bypass = w_empty && in_valid && !flush;
`else
    // No path from any in_* input reaches the outputs in this build.
    assign w_bypass = 1'b0;
`endif

    // in_ready depends only on state and flush, never on out_ready.
    assign in_ready  = !w_full && !flush;
    assign out_valid = w_head_valid || w_bypass;

    // A bypassed entry consumed in the same cycle never touches storage.
    assign w_push = in_valid && in_ready && !(w_bypass && out_ready);
    assign w_pop  = w_head_valid && out_ready;

    always_comb begin
        w_head_instr = NOP_INSTR;
        w_head_pc    = '0;
        if (w_bypass) begin
            w_head_instr = in_instr;
            w_head_pc    = in_pc;
        end else if (w_head_valid) begin
            w_head_instr = r_mem_instr[r_rd_ptr];
            w_head_pc    = r_mem_pc[r_rd_ptr];
        end
    end

    assign out_instr   = w_head_instr;
    assign out_pc      = w_head_pc;
    assign out_pcplus4 = out_valid ? (w_head_pc + ADDR_W'(4)) : '0;
    assign count       = r_count;

    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_mem_instr[r_wr_ptr] <= in_instr;
            r_mem_pc[r_wr_ptr]    <= in_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the modulo wrap.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_xgriscv_fetch_queue.sv
// tb/tb_xgriscv_fetch_queue.sv - directed scoreboard bench for xgriscv_fetch_queue

module tb_xgriscv_fetch_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] IMASK = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pcplus4;
    logic [2:0]  count;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    xgriscv_fetch_queue #(
        .ADDR_W (32),
        .INSTR_W(32),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .out_pcplus4(out_pcplus4),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the scoreboard model,
    // advance the clock, then update the model with what the edge should do.
    task automatic cycle(input logic rst, input logic fl, input logic inv,
                         input logic [31:0] pc, input logic ordy);
        logic        byp;
        logic        exp_vld;
        logic        exp_rdy;
        logic        do_push;
        logic        do_pop;
        ent_t        head;
        int          n;
        reset     = rst;
        flush     = fl;
        in_valid  = inv;
        in_pc     = pc;
        in_instr  = pc ^ IMASK;
        out_ready = ordy;
        #1;
        n = sb.size();
`ifdef XGRISCV_FQ_BYPASS_EN
        byp = (n == 0) && inv && !fl;
`else
        byp = 1'b0;
`endif
        exp_rdy = (n < DEPTH) && !fl;
        exp_vld = ((n != 0) && !fl) || byp;
        head.pc    = 32'h0;
        head.instr = NOP;
        if (byp) begin
            head.pc    = pc;
            head.instr = pc ^ IMASK;
        end else if (exp_vld) begin
            head = sb[0];
        end
        check("in_ready",    64'(in_ready),    64'(exp_rdy));
        check("out_valid",   64'(out_valid),   64'(exp_vld));
        check("count",       64'(count),       64'(n));
        check("out_pc",      64'(out_pc),      64'(head.pc));
        check("out_pcplus4", 64'(out_pcplus4), exp_vld ? 64'(32'(head.pc + 32'd4)) : 64'd0);
        check("out_instr",   64'(out_instr),   64'(head.instr));
        @(posedge clk);
        #1;
        if (rst || fl) begin
            sb.delete();
        end else begin
            do_pop  = (n != 0) && ordy;
            do_push = inv && (n < DEPTH) && !(byp && ordy);
            if (do_pop) void'(sb.pop_front());
            if (do_push) sb.push_back('{pc: pc, instr: pc ^ IMASK});
        end
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // reset state
        cycle(0, 0, 0, 32'h0, 0);

        // fill to full, fifth push ignored
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 32'(i * 4), 0);
        cycle(0, 0, 1, 32'h10, 0);
        check("full_count", 64'(count), 64'd4);

        // drain in order
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 32'h0, 1);
        cycle(0, 0, 0, 32'h0, 0);

        // flush with concurrent push and pop
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 32'h20 + 32'(i * 4), 0);
        cycle(0, 1, 1, 32'h80, 1);
        cycle(0, 0, 0, 32'h0, 0);

        // steady push+pop at count 2 across pointer wrap
        cycle(0, 0, 1, 32'h40, 0);
        cycle(0, 0, 1, 32'h44, 0);
        for (int i = 0; i < 10; i++) cycle(0, 0, 1, 32'h48 + 32'(i * 4), 1);
        check("steady_count", 64'(count), 64'd2);
        cycle(0, 0, 0, 32'h0, 1);
        cycle(0, 0, 0, 32'h0, 1);
        cycle(0, 0, 0, 32'h0, 0);

        // push into empty queue with decode ready
        cycle(0, 0, 1, 32'h100, 1);
        cycle(0, 0, 0, 32'h0, 1);
        cycle(0, 0, 0, 32'h0, 0);

        // pc+4 wraps to zero
        cycle(0, 0, 1, 32'hFFFF_FFFC, 0);
        cycle(0, 0, 0, 32'h0, 1);
        cycle(0, 0, 0, 32'h0, 0);

        // reset mid-operation with concurrent push
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 32'h300 + 32'(i * 4), 0);
        cycle(1, 0, 1, 32'h200, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 32'h0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
